// File: rtl/i2s_rx_deserializer.sv
// ---------------------------------------------------------------------------
// i2s_rx_deserializer
//   Recovers I2S serial audio (oversampled by clk) into parallel SAMPLE_W-bit
//   two's-complement words for one selected channel. Feeds the 16-tap FIR.
//
//   Ports
//     clk          system clock, must run at >= 4x bclk
//     rst          synchronous reset, active-high
//     i2s_bclk     serial bit clock (async)
//     i2s_lrclk    word select (async), 0 = left, 1 = right
//     i2s_sdata    serial data (async), MSB first, one bclk after lrclk edge
//     sound_org    last captured sample of channel CH_SEL, held between pulses
//     sound_valid  1-cycle pulse, sound_org updated this cycle
//     frame_err    1-cycle pulse, a slot ended before SAMPLE_W bits arrived
// ---------------------------------------------------------------------------
module i2s_rx_deserializer #(
    parameter int SAMPLE_W = 24,
    parameter int SLOT_W   = 32,
    parameter int CH_SEL   = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                i2s_bclk,
    input  logic                i2s_lrclk,
    input  logic                i2s_sdata,
    output logic [SAMPLE_W-1:0] sound_org,
    output logic                sound_valid,
    output logic                frame_err
);

    localparam int                CNT_W   = $clog2(SLOT_W);
    localparam logic [CNT_W-1:0]  CNT_LST = CNT_W'(SAMPLE_W - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(SLOT_W - 1);
    localparam logic              CH_LR   = (CH_SEL != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DELAY,
        S_SHIFT,
        S_PAD
    } state_t;

    // Synchronizers: plain data pipes, no reset needed. The third bclk stage
    // only exists for rising-edge detection.
    logic [2:0] r_bclk_sync;
    logic [1:0] r_lr_sync;
    logic [1:0] r_sd_sync;

    always_ff @(posedge clk) begin
        r_bclk_sync <= {r_bclk_sync[1:0], i2s_bclk};
        r_lr_sync   <= {r_lr_sync[0], i2s_lrclk};
        r_sd_sync   <= {r_sd_sync[0], i2s_sdata};
    end

    logic w_bclk_rise;
    logic w_lr;
    logic w_sd;

    assign w_bclk_rise = r_bclk_sync[1] & ~r_bclk_sync[2];
    assign w_lr        = r_lr_sync[1];
    assign w_sd        = r_sd_sync[1];

    state_t                r_state;
    state_t                w_state_nxt;
    logic [SAMPLE_W-2:0]   r_shift;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic                  r_lr_prev;
    logic                  r_primed;

    logic                  w_lr_edge;
    logic [SAMPLE_W-1:0]   w_word;
    logic                  w_shift;
    logic                  w_done;
    logic                  w_err;
    logic                  w_cnt_clr;
    logic                  w_cnt_inc;

    assign w_lr_edge = (w_lr != r_lr_prev);
    assign w_word    = {r_shift, w_sd};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // The lrclk edge rise carries the previous slot's last bit (I2S delay).
    // Entering DELAY marks that bit consumed, so the first rise spent in DELAY
    // is the MSB and is captured exactly like a SHIFT bit with bit_cnt=0.
    // When a slot has no padding, its LSB arrives on the edge rise itself, so
    // an edge with bit_cnt at the last position completes the word rather
    // than flagging a short slot.
    always_comb begin
        w_state_nxt = r_state;
        w_shift     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        if (w_bclk_rise) begin
            case (r_state)
                S_IDLE: begin
                    // first rise after reset only records lrclk
                    if (r_primed && w_lr_edge) begin
                        w_state_nxt = S_DELAY;
                        w_cnt_clr   = 1'b1;
                    end
                end
                S_DELAY, S_SHIFT: begin
                    if (r_bit_cnt == CNT_LST) begin
                        w_done = 1'b1;
                        if (w_lr_edge) begin
                            w_state_nxt = S_DELAY;
                            w_cnt_clr   = 1'b1;
                        end else begin
                            w_state_nxt = S_PAD;
                            w_cnt_inc   = 1'b1;
                        end
                    end else if (w_lr_edge) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_DELAY;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_shift     = 1'b1;
                        w_cnt_inc   = 1'b1;
                        w_state_nxt = S_SHIFT;
                    end
                end
                S_PAD: begin
                    if (w_lr_edge) begin
                        w_state_nxt = S_DELAY;
                        w_cnt_clr   = 1'b1;
                    end else begin
                        w_cnt_inc   = 1'b1;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // r_lr_prev still holds the completed slot's channel when the LSB lands
    // on the edge rise, so it selects the channel in both completion cases.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_shift     <= '0;
            r_bit_cnt   <= '0;
            r_lr_prev   <= 1'b0;
            r_primed    <= 1'b0;
            sound_org   <= '0;
            sound_valid <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            sound_valid <= w_done && (r_lr_prev == CH_LR);
            frame_err   <= w_err;
            if (w_bclk_rise) begin
                r_lr_prev <= w_lr;
                r_primed  <= 1'b1;
            end
            if (w_cnt_clr)
                r_bit_cnt <= '0;
            else if (w_cnt_inc && (r_bit_cnt != CNT_MAX))
                r_bit_cnt <= r_bit_cnt + 1'b1;
            if (w_shift || w_done)
                r_shift <= w_word[SAMPLE_W-2:0];
            if (w_done && (r_lr_prev == CH_LR))
                sound_org <= w_word;
        end
    end

endmodule

// File: tb/tb_i2s_rx_deserializer.sv
`timescale 1ns/1ps
module tb_i2s_rx_deserializer;

    localparam int K_NONE  = 0;
    localparam int K_VALID = 1;
    localparam int K_ERR   = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i2s_bclk = 1'b1;
    logic        i2s_lrclk = 1'b1;
    logic        i2s_sdata = 1'b0;
    logic [23:0] sound_org;
    logic        sound_valid;
    logic        frame_err;

    i2s_rx_deserializer #(.SAMPLE_W(24), .SLOT_W(32), .CH_SEL(0)) dut (
        .clk         (clk),
        .rst         (rst),
        .i2s_bclk    (i2s_bclk),
        .i2s_lrclk   (i2s_lrclk),
        .i2s_sdata   (i2s_sdata),
        .sound_org   (sound_org),
        .sound_valid (sound_valid),
        .frame_err   (frame_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        is_err;
        logic [23:0] val;
    } exp_t;

    exp_t sbq[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   half   = 40;      // bclk half period in ns (8x clk)
    logic prev_d = 1'b0;    // data lags lrclk by one bclk
    logic rst_q  = 1'b1;

    always @(posedge clk) rst_q <= rst;

    // Monitor: reset state checks and scoreboard pops.
    always @(negedge clk) begin
        if (rst_q) begin
            n_chk++;
            if (sound_org != 24'h0 || sound_valid || frame_err) begin
                n_fail++;
                $display("FAIL reset_state: org=%h valid=%b err=%b, need 0/0/0",
                         sound_org, sound_valid, frame_err);
            end
        end else if (sound_valid || frame_err) begin
            n_chk++;
            if (sound_valid && frame_err) begin
                n_fail++;
                $display("FAIL both_pulses: valid and frame_err together at %0t", $time);
            end else if (sbq.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_event: valid=%b err=%b org=%h, none expected",
                         sound_valid, frame_err, sound_org);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                if (e.is_err != frame_err || (!e.is_err && e.val != sound_org)) begin
                    n_fail++;
                    $display("FAIL scoreboard: got err=%b org=%h, need err=%b org=%h",
                             frame_err, sound_org, e.is_err, e.val);
                end
            end
        end
    end

    task automatic send_bit(input logic lr, input logic d);
        i2s_bclk  = 1'b0;
        i2s_lrclk = lr;
        i2s_sdata = d;
        #(half);
        i2s_bclk  = 1'b1;
        #(half);
    endtask

    // One slot of len bclk periods: word MSB first, zero padded / truncated.
    task automatic slot(input logic lr, input logic [23:0] w, input int len,
                        input int kind, input int rst_bit, input logic rst_val);
        exp_t e;
        if (kind == K_VALID) begin
            e.is_err = 1'b0; e.val = w; sbq.push_back(e);
        end else if (kind == K_ERR) begin
            e.is_err = 1'b1; e.val = 24'h0; sbq.push_back(e);
        end
        for (int i = 0; i < len; i++) begin
            if (i == rst_bit) rst = rst_val;
            send_bit(lr, prev_d);
            prev_d = (i < 24) ? w[23-i] : 1'b0;
        end
    endtask

    task automatic drain(input string name);
        repeat (12) @(negedge clk);
        n_chk++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_pending: %0d expected events never seen, need 0", name, sbq.size());
            sbq.delete();
        end
    endtask

    initial begin
        #(1_000_000);
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        #2;
        // T1 reset with bclk running, T2 left capture at 8x
        slot(1'b1, 24'h123456, 32, K_NONE, 8, 1'b0);
        for (int f = 0; f < 3; f++) begin
            slot(1'b0, 24'h800001, 32, K_VALID, -1, 1'b0);
            slot(1'b1, 24'h123456, 32, K_NONE,  -1, 1'b0);
        end
        drain("t2");

        // T3 reset released at bit 10 of a left slot
        rst = 1'b1;
        slot(1'b0, 24'hABCDEF, 32, K_NONE,  10, 1'b0);
        slot(1'b1, 24'h111111, 32, K_NONE,  -1, 1'b0);
        slot(1'b0, 24'h7FFFFF, 32, K_VALID, -1, 1'b0);
        drain("t3");

        // T4 short left slot, then recovery
        slot(1'b1, 24'h222222, 32, K_NONE,  -1, 1'b0);
        slot(1'b0, 24'hDEAD00, 16, K_ERR,   -1, 1'b0);
        slot(1'b1, 24'h333333, 32, K_NONE,  -1, 1'b0);
        slot(1'b0, 24'h5A5A5A, 32, K_VALID, -1, 1'b0);
        drain("t4");

        // zero-padding slots: LSB lands on the lrclk edge rise
        slot(1'b1, 24'h0C0C0C, 24, K_NONE,  -1, 1'b0);
        slot(1'b0, 24'hC3A501, 24, K_VALID, -1, 1'b0);
        slot(1'b1, 24'h000000, 32, K_NONE,  -1, 1'b0);
        drain("pad0");

        // T5 reset at bit 12 of a left slot, released in the right slot
        slot(1'b0, 24'h0F0F0F, 32, K_NONE,  12, 1'b1);
        slot(1'b1, 24'h444444, 32, K_NONE,  4,  1'b0);
        @(negedge clk);
        n_chk++;
        if (sound_org != 24'h0) begin
            n_fail++;
            $display("FAIL t5_hold: org=%h, need 000000", sound_org);
        end
        slot(1'b0, 24'h654321, 32, K_VALID, -1, 1'b0);
        drain("t5");

        // T6 random stream at 4x
        half = 20;
        for (int f = 0; f < 64; f++) begin
            slot(1'b1, 24'($urandom), 32, K_NONE,  -1, 1'b0);
            slot(1'b0, 24'($urandom), 32, K_VALID, -1, 1'b0);
        end
        slot(1'b1, 24'h000000, 32, K_NONE, -1, 1'b0);
        drain("t6");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
